// File: rtl/hilo_unit_if.sv
// HI/LO register-file bus: write, read, accumulate request and status.
// The bench drives the master side and the hilo_unit core is the slave.
interface hilo_unit_if #(
    parameter int W = 32
);
    logic             stall;
    logic             flush;
    logic             we_hi;
    logic             we_lo;
    logic [2*W-1:0]   wdata;
    logic [1:0]       rd_sel;
    logic [W-1:0]     rdata;
    logic             acc_valid;
    logic [1:0]       acc_op;
    logic [W-1:0]     acc_a;
    logic [W-1:0]     acc_b;
    logic             acc_busy;
    logic             acc_done;

    modport master (
        output stall, flush, we_hi, we_lo, wdata, rd_sel,
        output acc_valid, acc_op, acc_a, acc_b,
        input  rdata, acc_busy, acc_done
    );

    modport slave (
        input  stall, flush, we_hi, we_lo, wdata, rd_sel,
        input  acc_valid, acc_op, acc_a, acc_b,
        output rdata, acc_busy, acc_done
    );
endinterface

// File: rtl/hilo_unit.sv
// MIPS-style HI/LO register pair with direct writes, combinational read and an
// optional multiply-accumulate pipeline built only when HILO_ACC_EN is defined.
module hilo_unit #(
    parameter int W = 32
) (
    input  logic        clk,
    input  logic        rst,
    hilo_unit_if.slave  bus
);

    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic           w_busy;
    logic           w_commit;
    logic           w_wr_ok;
    logic [2*W-1:0] w_acc_sum;

    // Direct writes only land when the pipeline is neither stalled nor accumulating.
    assign w_wr_ok = ~bus.stall & ~w_busy;

`ifdef HILO_ACC_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_ADD  = 2'b10
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_capture;
    logic [1:0]     r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_prod;
    logic [2*W-1:0] w_prod;
    logic           w_ext_a;
    logic           w_ext_b;
    logic           r_done;

    // Accumulate FSM next state; stall outranks flush, flush only aborts MUL.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.stall && bus.acc_valid && !bus.flush) begin
                    w_state_nxt = ST_MUL;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (bus.stall) begin
                    w_state_nxt = ST_MUL;
                end else if (bus.flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ADD;
                end
            end
            ST_ADD: begin
                if (bus.stall) begin
                    w_state_nxt = ST_ADD;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_commit    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One shared 2W-bit multiplier: signed ops sign-extend, unsigned ops zero-extend.
    assign w_ext_a = ~r_op[0] & r_a[W-1];
    assign w_ext_b = ~r_op[0] & r_b[W-1];
    assign w_prod  = {{W{w_ext_a}}, r_a} * {{W{w_ext_b}}, r_b};

    // Add or subtract the registered product against the current HI/LO pair.
    always_comb begin
        w_acc_sum = {r_hi, r_lo};
        if (r_op[1]) begin
            w_acc_sum = {r_hi, r_lo} - r_prod;
        end else begin
            w_acc_sum = {r_hi, r_lo} + r_prod;
        end
    end

    // FSM state, captured operands, product register and done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op    <= 2'b00;
            r_a     <= {W{1'b0}};
            r_b     <= {W{1'b0}};
            r_prod  <= {(2*W){1'b0}};
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_commit;
            if (w_capture) begin
                r_op <= bus.acc_op;
                r_a  <= bus.acc_a;
                r_b  <= bus.acc_b;
            end
            if (r_state == ST_MUL && !bus.stall) begin
                r_prod <= w_prod;
            end
        end
    end

    assign w_busy       = (r_state != ST_IDLE);
    assign bus.acc_busy = w_busy;
    assign bus.acc_done = r_done;
`else
    assign w_busy       = 1'b0;
    assign w_commit     = 1'b0;
    assign w_acc_sum    = {(2*W){1'b0}};
    assign bus.acc_busy = 1'b0;
    assign bus.acc_done = 1'b0;
`endif

    // HI/LO storage: an accumulate commit and a direct write never coincide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hi <= {W{1'b0}};
            r_lo <= {W{1'b0}};
        end else if (w_commit) begin
            r_hi <= w_acc_sum[2*W-1:W];
            r_lo <= w_acc_sum[W-1:0];
        end else if (w_wr_ok) begin
            if (bus.we_hi) begin
                r_hi <= bus.wdata[2*W-1:W];
            end
            if (bus.we_lo) begin
                r_lo <= bus.wdata[W-1:0];
            end
        end
    end

    // Read port reflects registered state only, never an in-flight write.
    always_comb begin
        bus.rdata = {W{1'b0}};
        case (bus.rd_sel)
            2'b01:   bus.rdata = r_hi;
            2'b10:   bus.rdata = r_lo;
            default: bus.rdata = {W{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit; accumulate scenarios are built when HILO_ACC_EN
// is defined, otherwise the bench checks that accumulate requests are ignored.
module tb_hilo_unit;

    logic clk;
    logic rst;
    int   vecs;
    int   errs;

    hilo_unit_if #(.W(32)) bus ();

    hilo_unit #(.W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_hilo(input string tag, input logic [63:0] exp);
        logic [31:0] h;
        logic [31:0] l;
        bus.rd_sel = 2'b01;
        #1 h = bus.rdata;
        bus.rd_sel = 2'b10;
        #1 l = bus.rdata;
        bus.rd_sel = 2'b00;
        chk(tag, {h, l}, exp);
    endtask

    task automatic wr(input logic hi_en, input logic lo_en, input logic [63:0] data);
        bus.we_hi = hi_en;
        bus.we_lo = lo_en;
        bus.wdata = data;
        tick();
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
    endtask

    task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.acc_valid = 1'b1;
        bus.acc_op    = op;
        bus.acc_a     = a;
        bus.acc_b     = b;
        tick();
        bus.acc_valid = 1'b0;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst           = 1'b0;
        bus.stall     = 1'b1;
        bus.flush     = 1'b0;
        bus.we_hi     = 1'b1;
        bus.we_lo     = 1'b1;
        bus.wdata     = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.rd_sel    = 2'b00;
        bus.acc_valid = 1'b1;
        bus.acc_op    = 2'b00;
        bus.acc_a     = 32'h0000_0007;
        bus.acc_b     = 32'h0000_0009;

        // Reset with noisy inputs: everything must read zero.
        tick();
        tick();
        chk("rst_busy", {63'd0, bus.acc_busy}, 64'd0);
        chk("rst_done", {63'd0, bus.acc_done}, 64'd0);
        chk_hilo("rst_hilo", 64'd0);
        bus.stall     = 1'b0;
        bus.we_hi     = 1'b0;
        bus.we_lo     = 1'b0;
        bus.acc_valid = 1'b0;
        rst           = 1'b1;
        tick();

        wr(1'b1, 1'b1, 64'h1111_2222_3333_4444);
        chk_hilo("wr_both", 64'h1111_2222_3333_4444);
        wr(1'b0, 1'b1, 64'hAAAA_AAAA_DEAD_BEEF);
        chk_hilo("wr_lo_only", 64'h1111_2222_DEAD_BEEF);
        wr(1'b1, 1'b0, 64'hCAFE_F00D_5555_5555);
        chk_hilo("wr_hi_only", 64'hCAFE_F00D_DEAD_BEEF);

        bus.stall = 1'b1;
        wr(1'b1, 1'b1, 64'h0102_0304_0506_0708);
        bus.stall = 1'b0;
        chk_hilo("wr_stalled", 64'hCAFE_F00D_DEAD_BEEF);

        bus.rd_sel = 2'b00;
        #1 chk("rd_sel00", {32'd0, bus.rdata}, 64'd0);
        bus.rd_sel = 2'b11;
        #1 chk("rd_sel11", {32'd0, bus.rdata}, 64'd0);

        // Write pending before the edge must not bypass to rdata.
        bus.we_hi  = 1'b1;
        bus.wdata  = 64'h1234_5678_0000_0000;
        bus.rd_sel = 2'b01;
        #1 chk("no_bypass", {32'd0, bus.rdata}, 64'h0000_0000_CAFE_F00D);
        tick();
        bus.we_hi = 1'b0;
        chk_hilo("after_bypass", 64'h1234_5678_DEAD_BEEF);

`ifdef HILO_ACC_EN
        // MADD -2*3 on {0,5} gives -1.
        wr(1'b1, 1'b1, 64'h0000_0000_0000_0005);
        start(2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
        chk("madd_busy1", {63'd0, bus.acc_busy}, 64'd1);
        tick();
        chk("madd_busy2", {63'd0, bus.acc_busy}, 64'd1);
        chk("madd_nodone", {63'd0, bus.acc_done}, 64'd0);
        tick();
        chk("madd_idle", {63'd0, bus.acc_busy}, 64'd0);
        chk("madd_done", {63'd0, bus.acc_done}, 64'd1);
        chk_hilo("madd_val", 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("madd_done_off", {63'd0, bus.acc_done}, 64'd0);

        // MSUBU FFFFFFFF*2 from zero wraps modulo 2^64.
        wr(1'b1, 1'b1, 64'd0);
        start(2'b11, 32'hFFFF_FFFF, 32'h0000_0002);
        tick();
        tick();
        chk("msubu_done", {63'd0, bus.acc_done}, 64'd1);
        chk_hilo("msubu_val", 64'hFFFF_FFFE_0000_0002);

        // Flush while in MUL: abort, no commit, no done.
        start(2'b00, 32'h0000_0001, 32'h0000_0001);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_idle", {63'd0, bus.acc_busy}, 64'd0);
        chk("flush_nodone0", {63'd0, bus.acc_done}, 64'd0);
        tick();
        chk("flush_nodone1", {63'd0, bus.acc_done}, 64'd0);
        chk_hilo("flush_val", 64'hFFFF_FFFE_0000_0002);

        // MADDU with a dropped HI write in MUL and a 3-cycle stall in ADD.
        start(2'b01, 32'h0000_0002, 32'h0000_0003);
        wr(1'b1, 1'b0, 64'h1234_5678_0000_0000);
        chk_hilo("busy_wr_drop", 64'hFFFF_FFFE_0000_0002);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_busy", {63'd0, bus.acc_busy}, 64'd1);
            chk("stall_nodone", {63'd0, bus.acc_done}, 64'd0);
        end
        chk_hilo("stall_val", 64'hFFFF_FFFE_0000_0002);
        bus.stall = 1'b0;
        tick();
        chk("stall_done", {63'd0, bus.acc_done}, 64'd1);
        chk_hilo("stall_commit", 64'hFFFF_FFFE_0000_0008);

        // Write and capture in the same cycle: ADD sees the written value.
        bus.we_hi = 1'b1;
        bus.we_lo = 1'b1;
        bus.wdata = 64'h0000_0000_0000_0010;
        start(2'b00, 32'h0000_0002, 32'h0000_0002);
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
        tick();
        tick();
        chk_hilo("wr_then_acc", 64'h0000_0000_0000_0014);

        // Reset while in MUL.
        start(2'b00, 32'h0000_0003, 32'h0000_0003);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rstmul_busy", {63'd0, bus.acc_busy}, 64'd0);
        chk_hilo("rstmul_val", 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rstmul_nodone", {63'd0, bus.acc_done}, 64'd0);
        end
`else
        // Without the accumulator, requests must have no effect.
        start(2'b00, 32'h0000_0002, 32'h0000_0003);
        chk("noacc_busy", {63'd0, bus.acc_busy}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("noacc_done", {63'd0, bus.acc_done}, 64'd0);
        end
        chk_hilo("noacc_val", 64'h1234_5678_DEAD_BEEF);
        wr(1'b0, 1'b1, 64'h0000_0000_0BAD_F00D);
        chk_hilo("noacc_wr", 64'h1234_5678_0BAD_F00D);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_hilo("rst_again", 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have parameter W, default 32: width of each of HI and LO.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  pipeline stall; freezes all state.
REQ-005 SHALL have port flush  input  1  pipeline flush; aborts an in-flight accumulate per REQ-016.
REQ-006 SHALL have port we_hi  input  1  write HI from wdata[2W-1:W].
REQ-007 SHALL have port we_lo  input  1  write LO from wdata[W-1:0].
REQ-008 SHALL have port wdata  input  2W  write data: mul/div result, or MTHI/MTLO operand in the relevant half.
REQ-009 SHALL have port rd_sel  input  2  read select: 00 none, 01 HI, 10 LO, 11 none.
REQ-010 SHALL have port rdata  output  W  read data.
REQ-011 SHALL have ports acc_valid (input, 1), acc_op (input, 2; 00 MADD, 01 MADDU, 10 MSUB, 11 MSUBU), acc_a and acc_b (input, W each): accumulate request.
REQ-012 SHALL have ports acc_busy (output, 1) and acc_done (output, 1): accumulate status.

Function
REQ-013 SHALL drive rdata combinationally from the registered HI/LO: HI when rd_sel=01, LO when rd_sel=10, zero otherwise; no same-cycle bypass of a write.
REQ-014 SHALL, when stall=0 and acc_busy=0, update HI on we_hi and LO on we_lo independently at the clock edge; a write while acc_busy=1 or stall=1 SHALL be dropped.
REQ-015 SHALL implement a three-state accumulate FSM:
- IDLE: acc_valid=1, stall=0 and flush=0 capture acc_op, acc_a, acc_b and go to MUL.
- MUL: registers the 2W-bit product (signed for 00/10, unsigned for 01/11), then goes to ADD.
- ADD: writes {HI,LO} <= {HI,LO} + product (MADD/MADDU) or - product (MSUB/MSUBU), modulo 2^(2W), then goes to IDLE.
REQ-016 SHALL, on flush=1 in MUL, return to IDLE with HI/LO unchanged; flush in ADD SHALL be ignored (commit completes); flush in IDLE SHALL block a same-cycle capture.
REQ-017 SHALL hold the FSM state, captured operands and product unchanged while stall=1; stall SHALL take priority over flush.
REQ-018 SHALL drive acc_busy=1 in MUL and ADD and 0 in IDLE; acc_valid SHALL be ignored while acc_busy=1.
REQ-019 SHALL drive acc_done as a registered one-cycle pulse in the cycle after the ADD commit edge; HI/LO SHALL read the new value in that same cycle.
REQ-020 SHALL give a direct write (we_hi/we_lo) priority over capture when both occur in IDLE: the write commits and the accumulate still starts, using the updated HI/LO at ADD.
REQ-021 SHALL have a latency of 3 edges from acceptance to HI/LO update, with no stalls.

Reset
REQ-022 SHALL, when rst=0 at a clock edge, clear HI, LO, the product register and the captured operands to 0, force the FSM to IDLE and clear acc_done, regardless of stall, flush or any in-flight operation.
REQ-023 SHALL, during and after reset, show acc_busy=0, acc_done=0 and rdata=0.

Configuration
REQ-024 SHALL compile in the accumulate FSM only when macro HILO_ACC_EN is defined.
REQ-025 SHALL, without HILO_ACC_EN, keep all ports, ignore acc_valid, acc_op, acc_a and acc_b, tie acc_busy=0 and acc_done=0, and contain no multiplier; REQ-013/014 behaviour is unchanged.

Verification
REQ-026 SHALL cover: reset, then wdata=64'h11112222_33334444 with we_hi=we_lo=1 -> next cycle rd_sel=01 gives 32'h11112222 and rd_sel=10 gives 32'h33334444.
REQ-027 SHALL cover: we_lo only with wdata low=32'hDEADBEEF -> LO=DEADBEEF, HI unchanged.
REQ-028 SHALL cover (HILO_ACC_EN): HI/LO=0/5, MADD a=-2 b=3 -> acc_busy for 2 cycles, acc_done pulses, {HI,LO}=64'hFFFFFFFF_FFFFFFFF (i.e. -1).
REQ-029 SHALL cover (HILO_ACC_EN): MSUBU a=32'hFFFFFFFF b=2 from 0 -> {HI,LO}=64'hFFFFFFFE_00000002 (modulo wrap).
REQ-030 SHALL cover: flush in MUL -> no commit, no acc_done; stall for 3 cycles in ADD -> commit delayed 3 cycles with values intact; we_hi while busy -> dropped.
REQ-031 SHALL cover: rst=0 asserted in MUL -> IDLE, HI=LO=0, and acc_done never pulses.
